mac_accum_tx: RTL and testbench

//  Producer side of the aggregator input bus. Sums a programmable number of signed
//  MAC products into one partial sum. Hands the N-bit result to the aggregator over a

---
 rtl/mac_accum_tx.sv | 154 +++++++++++++++
 tb/tb_mac_accum_tx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mac_accum_tx.sv
// rtl/mac_accum_tx.sv - signed MAC product accumulator feeding the aggregator input bus
//
// Purpose:
//   Sums a programmable number of signed products from the MAC array into one
//   partial sum. The sum is then presented to the aggregator over a valid/ready
//   handshake.
//
// Optional feature macro:
//   MAC_ACCUM_SAT_EN  defined   -> agg_in_data is acc clamped to the N-bit signed range
//                     undefined -> agg_in_data is acc[N-1:0] (wrap-around)
//   ovf behaves the same in both builds.
//
// Ports:
//   clk           in   1       clock, rising edge
//   rst           in   1       asynchronous reset, active high
//   start         in   1       begin a new sum (sampled in IDLE only)
//   num_terms     in   CNT_W   products per sum, latched on accepted start
//   prod_in       in   PROD_W  signed product
//   prod_valid    in   1       prod_in valid
//   prod_ready    out  1       product accepted this cycle (decoded from state)
//   agg_in_data   out  N       saturated/truncated sum
//   agg_in_valid  out  1       agg_in_data valid
//   agg_in_ready  in   1       aggregator accepts result
//   busy          out  1       state is not IDLE
//   ovf           out  1       sticky per sum: result exceeded N-bit signed range
module mac_accum_tx #(
  parameter int N      = 12,
  parameter int PROD_W = 12,
  parameter int CNT_W  = 8,
  parameter int ACC_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_terms,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [N-1:0]      agg_in_data,
  output logic              agg_in_valid,
  input  logic              agg_in_ready,
  output logic              busy,
  output logic              ovf
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;

  // Bounds of the N-bit signed range, expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};

  logic [1:0]              state_q, state_d;
  logic [CNT_W-1:0]        terms_q, terms_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [N-1:0]            data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    ovf_q, ovf_d;

  logic signed [ACC_W-1:0] acc_sum;
  logic                    sum_hi, sum_lo;
  logic [N-1:0]            sum_out;

  // Running sum including the product offered this cycle; used both to update
  // acc and to load the result on the last term so SEND follows with no gap.
  assign acc_sum = acc_q + {{(ACC_W-PROD_W){prod_in[PROD_W-1]}}, prod_in};
  assign sum_hi  = (acc_sum > MAX_V);
  assign sum_lo  = (acc_sum < MIN_V);

`ifdef MAC_ACCUM_SAT_EN
  assign sum_out = sum_hi ? MAX_V[N-1:0] : (sum_lo ? MIN_V[N-1:0] : acc_sum[N-1:0]);
`else
  assign sum_out = acc_sum[N-1:0];
`endif

  always_comb begin
    state_d = state_q;
    terms_d = terms_q;
    count_d = count_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          terms_d = num_terms;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          if (num_terms == '0) begin
            state_d = S_SEND;
            data_d  = '0;
            valid_d = 1'b1;
          end else begin
            state_d = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        if (prod_valid) begin
          acc_d   = acc_sum;
          count_d = count_q + CNT_W'(1);
          if (count_q == terms_q - CNT_W'(1)) begin
            state_d = S_SEND;
            data_d  = sum_out;
            valid_d = 1'b1;
            ovf_d   = sum_hi | sum_lo;
          end
        end
      end
      S_SEND: begin
        if (agg_in_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      terms_q <= '0;
      count_q <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      terms_q <= terms_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign prod_ready   = (state_q == S_ACCUM);
  assign agg_in_data  = data_q;
  assign agg_in_valid = valid_q;
  assign busy         = busy_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_mac_accum_tx.sv
// tb/tb_mac_accum_tx.sv - directed self-checking bench for mac_accum_tx
module tb_mac_accum_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  num_terms;
  logic [11:0] prod_in;
  logic        prod_valid;
  logic        prod_ready;
  logic [11:0] agg_in_data;
  logic        agg_in_valid;
  logic        agg_in_ready;
  logic        busy;
  logic        ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  mac_accum_tx dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_terms    (num_terms),
    .prod_in      (prod_in),
    .prod_valid   (prod_valid),
    .prod_ready   (prod_ready),
    .agg_in_data  (agg_in_data),
    .agg_in_valid (agg_in_valid),
    .agg_in_ready (agg_in_ready),
    .busy         (busy),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [11:0] t2 [4];
  logic [11:0] t3 [3];
  logic [11:0] exp_sat_pos, exp_sat_neg;

  initial begin
    t2[0] = 12'd5; t2[1] = -12'sd3; t2[2] = 12'd10; t2[3] = 12'd100;
    t3[0] = 12'd7; t3[1] = -12'sd20; t3[2] = 12'd1;
`ifdef MAC_ACCUM_SAT_EN
    exp_sat_pos = 12'h7FF;
    exp_sat_neg = 12'h800;
`else
    exp_sat_pos = 12'hFFE;
    exp_sat_neg = 12'h7FF;
`endif

    rst = 1'b1; start = 1'b0; num_terms = 8'd0; prod_in = '0;
    prod_valid = 1'b0; agg_in_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", agg_in_valid, 1'b0);
    chk("rst_data", agg_in_data, 12'h000);
    chk("rst_ready", prod_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Four back-to-back terms, aggregator always ready: 5-3+10+100 = 112.
    agg_in_ready = 1'b1;
    start = 1'b1; num_terms = 8'd4;
    @(negedge clk);
    start = 1'b0;
    chk("t2_prod_ready", prod_ready, 1'b1);
    chk("t2_busy", busy, 1'b1);
    prod_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      prod_in = t2[i];
      @(negedge clk);
      if (i == 2) chk("t2_valid_early", agg_in_valid, 1'b0);
    end
    prod_valid = 1'b0;
    chk("t2_valid", agg_in_valid, 1'b1);
    chk("t2_data", agg_in_data, 12'd112);
    chk("t2_ovf", ovf, 1'b0);
    chk("t2_send_ready", prod_ready, 1'b0);
    @(negedge clk);
    chk("t2_valid_drop", agg_in_valid, 1'b0);
    chk("t2_idle", busy, 1'b0);
    chk("t2_data_hold", agg_in_data, 12'd112);

    // Asynchronous reset in the middle of ACCUM discards the sum.
    start = 1'b1; num_terms = 8'd4;
    @(negedge clk);
    start = 1'b0; prod_valid = 1'b1; prod_in = 12'd9;
    repeat (2) @(negedge clk);
    prod_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t1_busy", busy, 1'b0);
    chk("t1_ready", prod_ready, 1'b0);
    chk("t1_data", agg_in_data, 12'h000);
    chk("t1_valid", agg_in_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Three terms with 2-cycle gaps, aggregator stalls for 5 cycles: 7-20+1 = -12.
    agg_in_ready = 1'b0;
    start = 1'b1; num_terms = 8'd3;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      prod_valid = 1'b1; prod_in = t3[i];
      @(negedge clk);
      prod_valid = 1'b0; prod_in = 12'h555;
      if (i < 2) begin
        repeat (2) @(negedge clk);
        chk("t3_gap_valid", agg_in_valid, 1'b0);
        chk("t3_gap_ready", prod_ready, 1'b1);
      end
    end
    for (int k = 0; k < 5; k++) begin
      chk("t3_hold_valid", agg_in_valid, 1'b1);
      chk("t3_hold_data", agg_in_data, 12'hFF4);
      chk("t3_hold_ready", prod_ready, 1'b0);
      @(negedge clk);
    end
    agg_in_ready = 1'b1;
    chk("t3_xfer_valid", agg_in_valid, 1'b1);
    @(negedge clk);
    chk("t3_after_valid", agg_in_valid, 1'b0);
    @(negedge clk);
    chk("t3_single", agg_in_valid, 1'b0);
    chk("t3_idle", busy, 1'b0);

    // Positive overflow: 2047+2047 = 4094.
    start = 1'b1; num_terms = 8'd2;
    @(negedge clk);
    start = 1'b0; prod_valid = 1'b1; prod_in = 12'd2047;
    repeat (2) @(negedge clk);
    prod_valid = 1'b0;
    chk("t4_data", agg_in_data, exp_sat_pos);
    chk("t4_ovf", ovf, 1'b1);
    @(negedge clk);
    chk("t4_ovf_sticky", ovf, 1'b1);

    // Negative overflow: -2048 + -1 = -2049.
    start = 1'b1; num_terms = 8'd2;
    @(negedge clk);
    start = 1'b0; prod_valid = 1'b1; prod_in = 12'h800;
    @(negedge clk);
    prod_in = 12'hFFF;
    @(negedge clk);
    prod_valid = 1'b0;
    chk("t4n_data", agg_in_data, exp_sat_neg);
    chk("t4n_ovf", ovf, 1'b1);
    @(negedge clk);

    // Zero terms: immediate send of 0, ovf cleared by the new start.
    start = 1'b1; num_terms = 8'd0;
    @(negedge clk);
    start = 1'b0;
    chk("t5_valid", agg_in_valid, 1'b1);
    chk("t5_data", agg_in_data, 12'h000);
    chk("t5_ovf", ovf, 1'b0);
    chk("t5_ready", prod_ready, 1'b0);
    @(negedge clk);
    chk("t5_idle", busy, 1'b0);

    // start and num_terms changes while busy are ignored: 30+40 = 70 over 2 terms.
    start = 1'b1; num_terms = 8'd2;
    @(negedge clk);
    num_terms = 8'd5; prod_valid = 1'b1; prod_in = 12'd30;
    @(negedge clk);
    start = 1'b0; prod_in = 12'd40;
    @(negedge clk);
    prod_valid = 1'b0;
    chk("t6_valid", agg_in_valid, 1'b1);
    chk("t6_data", agg_in_data, 12'd70);
    agg_in_ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t6_send_valid", agg_in_valid, 1'b1);
    chk("t6_send_data", agg_in_data, 12'd70);
    chk("t6_send_busy", busy, 1'b1);
    agg_in_ready = 1'b1;
    @(negedge clk);
    chk("t6_done_valid", agg_in_valid, 1'b0);
    @(negedge clk);
    chk("t6_no_restart", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
